// File: rtl/s2_burst_receiver_if.sv
// Valid/ready word channel between the m2 burst master and the s2 burst receiver.
interface s2_burst_receiver_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/s2_burst_receiver.sv
// Burst receiver: buffers BURST_LEN words, checks word n == n+1, then drains via a read port.
// Optional partial-burst discard after TIMEOUT idle cycles when RX_TIMEOUT_EN is defined.
module s2_burst_receiver #(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst,
    s2_burst_receiver_if.slave  bus,
    input  logic                rd_en,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                burst_done,
    output logic                seq_err,
    output logic [7:0]          err_cnt,
    output logic                timeout_pulse
);

    typedef enum logic {RECV, DRAIN} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

    if (BURST_LEN < 2 || BURST_LEN != (1 << CNT_W) || TIMEOUT < 1) begin : g_bad_params
        $error("s2_burst_receiver: BURST_LEN must equal 2**CNT_W (>=2) and TIMEOUT must be >= 1");
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic [CNT_W-1:0]    rcnt_q, rcnt_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                burst_done_q, burst_done_d;
    logic                seq_err_q, seq_err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [DATA_W-1:0]   mem_q [BURST_LEN];
    logic                mem_wr_en;
    logic                xfer;
    logic [DATA_W-1:0]   exp_word;

`ifdef RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                timeout_q, timeout_d;
`endif

    assign xfer     = bus.valid & ready_q;
    assign exp_word = DATA_W'(wcnt_q) + DATA_W'(1);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        ready_d      = ready_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        burst_done_d = 1'b0;
        seq_err_d    = seq_err_q;
        err_cnt_d    = err_cnt_q;
        mem_wr_en    = 1'b0;
`ifdef RX_TIMEOUT_EN
        idle_d       = '0;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            RECV: begin
                ready_d = 1'b1;
                if (xfer) begin
                    mem_wr_en = 1'b1;
                    if (bus.data != exp_word) begin
                        seq_err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end
                    // Final word: leave for DRAIN with ready dropping on the same edge.
                    if (wcnt_q == LAST) begin
                        burst_done_d = 1'b1;
                        wcnt_d       = '0;
                        state_d      = DRAIN;
                        ready_d      = 1'b0;
                    end else begin
                        wcnt_d = wcnt_q + CNT_W'(1);
                    end
                end
`ifdef RX_TIMEOUT_EN
                else if (!bus.valid && wcnt_q != '0) begin
                    if (idle_q == IDLE_LAST) begin
                        wcnt_d    = '0;
                        timeout_d = 1'b1;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
`endif
            end
            DRAIN: begin
                ready_d = 1'b0;
                if (rd_en) begin
                    rd_data_d  = mem_q[rcnt_q];
                    rd_valid_d = 1'b1;
                    if (rcnt_q == LAST) begin
                        rcnt_d  = '0;
                        state_d = RECV;
                        ready_d = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = RECV;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RECV;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            ready_q      <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            burst_done_q <= 1'b0;
            seq_err_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            ready_q      <= ready_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            burst_done_q <= burst_done_d;
            seq_err_q    <= seq_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // NOTE: the buffer is deliberately not reset; every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (mem_wr_en) mem_q[wcnt_q] <= bus.data;
    end

`ifdef RX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_pulse = timeout_q;
`else
    assign timeout_pulse = 1'b0;
`endif

    assign bus.ready  = ready_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign burst_done = burst_done_q;
    assign seq_err    = seq_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_s2_burst_receiver.sv
// Directed bench for s2_burst_receiver: queue-based reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_s2_burst_receiver;

    localparam int DATA_W    = 16;
    localparam int BURST_LEN = 8;
    localparam int CNT_W     = 3;
    localparam int TIMEOUT   = 16;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              burst_done;
    logic              seq_err;
    logic [7:0]        err_cnt;
    logic              timeout_pulse;

    int n_vec = 0;
    int n_err = 0;

    s2_burst_receiver_if #(.DATA_W(DATA_W)) bus ();

    s2_burst_receiver #(
        .DATA_W   (DATA_W),
        .BURST_LEN(BURST_LEN),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .burst_done   (burst_done),
        .seq_err      (seq_err),
        .err_cnt      (err_cnt),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words of the current burst and words waiting to be read.
    int         rx_words[$];
    int         pend[$];
    int         idle_cnt = 0;
    bit         m_ready  = 1'b0;
    bit         m_rdv    = 1'b0;
    bit         m_done   = 1'b0;
    bit         m_err    = 1'b0;
    bit         m_to     = 1'b0;
    int         m_cnt    = 0;
    logic [15:0] m_rdd   = '0;

    always @(posedge clk) begin
        if (rst) begin
            rx_words.delete();
            pend.delete();
            idle_cnt = 0;
            m_ready  = 1'b0;
            m_rdv    = 1'b0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_to     = 1'b0;
            m_cnt    = 0;
            m_rdd    = '0;
        end else begin
            m_rdv  = 1'b0;
            m_done = 1'b0;
            m_to   = 1'b0;
            if (pend.size() == 0) begin
                if (bus.valid && m_ready) begin
                    if (int'(bus.data) != rx_words.size() + 1) begin
                        m_err = 1'b1;
                        if (m_cnt < 255) m_cnt++;
                    end
                    rx_words.push_back(int'(bus.data));
                    idle_cnt = 0;
                    if (rx_words.size() == BURST_LEN) begin
                        pend = rx_words;
                        rx_words.delete();
                        m_done = 1'b1;
                    end
                end else if (!bus.valid && rx_words.size() != 0) begin
`ifdef RX_TIMEOUT_EN
                    idle_cnt++;
                    if (idle_cnt == TIMEOUT) begin
                        rx_words.delete();
                        idle_cnt = 0;
                        m_to     = 1'b1;
                    end
`endif
                end else begin
                    idle_cnt = 0;
                end
            end else if (rd_en) begin
                m_rdd = 16'(pend.pop_front());
                m_rdv = 1'b1;
            end
            m_ready = (pend.size() == 0);
        end
    end

    int done_seen = 0;
    int to_seen   = 0;

    always @(negedge clk) begin
        check("ready",         32'(bus.ready),     32'(m_ready));
        check("rd_valid",      32'(rd_valid),      32'(m_rdv));
        check("rd_data",       32'(rd_data),       32'(m_rdd));
        check("burst_done",    32'(burst_done),    32'(m_done));
        check("seq_err",       32'(seq_err),       32'(m_err));
        check("err_cnt",       32'(err_cnt),       32'(m_cnt));
        check("timeout_pulse", 32'(timeout_pulse), 32'(m_to));
        if (burst_done === 1'b1) done_seen++;
        if (timeout_pulse === 1'b1) to_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a word and holds valid until the edge that transfers it.
    task automatic send_word(input int w);
        int t = 0;
        bus.data  = 16'(w);
        bus.valid = 1'b1;
        while (bus.ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (t == 50) check("ready_wait", 32'(bus.ready), 32'd1);
        tick();
    endtask

    task automatic send_seq(input int w[8]);
        for (int i = 0; i < 8; i++) send_word(w[i]);
        bus.valid = 1'b0;
    endtask

    int got[$];

    task automatic read_n(input int n);
        got.delete();
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (rd_valid === 1'b1) got.push_back(int'(rd_data));
        end
        rd_en = 1'b0;
    endtask

    task automatic drain_expect(input string name, input int w[8]);
        read_n(8);
        check({name, "_count"}, 32'(got.size()), 32'd8);
        for (int i = 0; i < 8; i++) check(name, (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(w[i]));
    endtask

    int good[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int bad4[8] = '{1, 2, 3, 9, 5, 6, 7, 8};
    int zero[8] = '{0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        int d0;
        bus.data  = '0;
        bus.valid = 1'b0;
        rst       = 1'b1;
        repeat (2) tick();
        check("reset_ready", 32'(bus.ready), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;

        // Clean burst with valid held high from the first cycle.
        bus.valid = 1'b1;
        bus.data  = 16'd1;
        tick();
        check("ready_cycle1", 32'(bus.ready), 32'd1);
        send_seq(good);
        check("clean_done", 32'(burst_done), 32'd1);
        check("clean_ready_low", 32'(bus.ready), 32'd0);
        check("clean_seq_err", 32'(seq_err), 32'd0);

        // Backpressure: master pushes while the buffer is full.
        bus.valid = 1'b1;
        bus.data  = 16'h00AA;
        repeat (3) tick();
        check("bp_ready", 32'(bus.ready), 32'd0);
        bus.valid = 1'b0;
        drain_expect("drain1", good);
        check("drain_ready_back", 32'(bus.ready), 32'd1);

        // Gapped valid: one burst despite a 5-cycle hole.
        d0 = done_seen;
        for (int i = 1; i <= 3; i++) send_word(i);
        bus.valid = 1'b0;
        repeat (5) tick();
        for (int i = 4; i <= 8; i++) send_word(i);
        bus.valid = 1'b0;
        tick();
        check("gap_done_once", 32'(done_seen - d0), 32'd1);
        check("gap_err_cnt", 32'(err_cnt), 32'd0);
        drain_expect("drain_gap", good);

        // Reset in the middle of a burst abandons it.
        for (int i = 1; i <= 3; i++) send_word(i);
        bus.valid = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_ready", 32'(bus.ready), 32'd0);
        rst = 1'b0;
        send_seq(good);
        check("midrst_done", 32'(burst_done), 32'd1);
        check("midrst_seq_err", 32'(seq_err), 32'd0);
        drain_expect("drain_rst", good);

`ifdef RX_TIMEOUT_EN
        // Partial burst discarded after TIMEOUT idle cycles.
        for (int i = 1; i <= 3; i++) send_word(i);
        bus.valid = 1'b0;
        d0 = to_seen;
        repeat (TIMEOUT + 2) tick();
        check("timeout_once", 32'(to_seen - d0), 32'd1);
        send_seq(good);
        check("after_to_err", 32'(err_cnt), 32'd0);
        drain_expect("drain_to", good);
`else
        // Without the timeout a partial burst simply waits.
        for (int i = 1; i <= 3; i++) send_word(i);
        bus.valid = 1'b0;
        repeat (TIMEOUT + 4) tick();
        check("no_timeout", 32'(to_seen), 32'd0);
        for (int i = 4; i <= 8; i++) send_word(i);
        bus.valid = 1'b0;
        check("wait_done", 32'(burst_done), 32'd1);
        check("wait_err_cnt", 32'(err_cnt), 32'd0);
        drain_expect("drain_wait", good);
`endif

        // Sequence error in word 4.
        for (int i = 0; i < 8; i++) begin
            send_word(bad4[i]);
            if (i == 3) begin
                check("seq_err_set", 32'(seq_err), 32'd1);
                check("err_cnt_one", 32'(err_cnt), 32'd1);
            end
        end
        bus.valid = 1'b0;
        check("err_burst_done", 32'(burst_done), 32'd1);
        drain_expect("drain_err", bad4);

        // 256 more bad words saturate the counter.
        for (int b = 0; b < 32; b++) begin
            send_seq(zero);
            read_n(8);
        end
        tick();
        check("err_cnt_sat", 32'(err_cnt), 32'd255);
        check("seq_err_sticky", 32'(seq_err), 32'd1);

        // Receiver still returns to normal operation after saturation.
        send_seq(good);
        drain_expect("drain_final", good);
        check("err_cnt_held", 32'(err_cnt), 32'd255);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before t=200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/s2_burst_receiver.md
Name: s2_burst_receiver

Overview:
- Receiving end of the 16-bit valid/ready burst interface driven by the m2 master.
- Accepts bursts of BURST_LEN words into an internal buffer and checks each word against the expected sequence: word n carries value n+1.
- Signals completion, then holds off the master (ready low) until a local consumer drains the buffer through a simple read port.

Parameters:
- DATA_W, 16, width of data bus and buffer entries
- BURST_LEN, 8, words per burst; power of two, at least 2
- CNT_W, 3, width of word/read counters, equal to log2(BURST_LEN)
- TIMEOUT, 16, idle cycles before a partial burst is discarded (used only with RX_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- data  in  DATA_W  word from master
- valid  in  1  master word valid
- ready  out  1  receiver can accept; registered
- rd_en  in  1  consumer read request; honoured only in DRAIN
- rd_data  out  DATA_W  buffered word; registered
- rd_valid  out  1  one-cycle pulse, rd_data valid
- burst_done  out  1  one-cycle pulse, final word of a burst accepted
- seq_err  out  1  sticky sequence-mismatch flag; cleared only by rst
- err_cnt  out  8  count of mismatched words, saturates at 255
- timeout_pulse  out  1  one-cycle pulse on partial-burst discard; tied 0 without RX_TIMEOUT_EN

Behaviour:
- Transfer: occurs on a rising clk edge where valid=1 and ready=1. No other condition transfers a word.
- Reset (rst=1 at edge):
  - state=RECV, wcnt=0, rcnt=0
  - ready, rd_valid, burst_done, seq_err, timeout_pulse all 0; rd_data=0; err_cnt=0
  - Buffer contents are don't-care.
- RECV state:
  - ready<=1 every cycle, so ready is first high one cycle after rst deasserts.
  - On transfer: buf[wcnt]<=data, and data is compared with zero-extended wcnt+1.
  - On mismatch: seq_err<=1; err_cnt<=err_cnt+1 unless already 255.
  - wcnt increments on each transfer.
  - valid low: wcnt holds; no timeout without the macro.
  - Transfer with wcnt=BURST_LEN-1: burst_done<=1 for one cycle, wcnt wraps to 0, state<=DRAIN, ready<=0 at the same edge. No extra word can be accepted.
- DRAIN state:
  - ready held 0; valid/data ignored.
  - rd_en=1: rd_data<=buf[rcnt], rd_valid<=1 on the next cycle, rcnt increments.
  - rd_en=0: rd_valid<=0.
  - Read with rcnt=BURST_LEN-1: rcnt wraps to 0, state<=RECV, ready<=1 at the same edge. The next transfer is possible one cycle after the final read edge.
- rd_en in RECV: ignored; rd_valid stays 0, rd_data holds its last value.
- burst_done and rd_valid are never high in the same cycle as the burst-completing transfer's neighbour read, because the states are exclusive.
- Data width: comparison is full DATA_W, with the counter zero-extended.
- Reset mid-burst or mid-drain: partial data is abandoned. Counters and flags return to their reset values on the same edge.

Optional Feature:
- Macro: RX_TIMEOUT_EN
- Defined:
  - In RECV with wcnt!=0, an idle counter counts consecutive cycles with valid=0; any transfer clears it.
  - When it reaches TIMEOUT: wcnt<=0, idle counter<=0, timeout_pulse<=1 for one cycle. State stays RECV and ready stays 1; seq_err and err_cnt are unchanged.
  - The idle counter is held at 0 in DRAIN and when wcnt=0.
- Not defined: no idle counter; timeout_pulse is constant 0; a partial burst waits indefinitely.

Test Plan:
- Clean burst: after rst, drive words 1..8 with valid constant high -> ready high from cycle 1; burst_done pulses on the 8th transfer; ready=0 the next cycle; seq_err=0, err_cnt=0.
- Drain: after the clean burst, hold rd_en high for 8 cycles -> rd_valid pulses 8 times with rd_data 1,2,...,8; ready returns to 1 the cycle after the 8th read edge.
- Backpressure: in DRAIN, drive valid=1 with data 0x00AA -> no transfer; buffer unchanged; subsequent reads still return 1..8.
- Sequence error: send burst 1,2,3,9,5,6,7,8 -> seq_err=1 after the 4th transfer; err_cnt=1; burst_done still pulses. Then 255 bad words -> err_cnt stays 255.
- Gapped valid/reset: send 1,2,3, drop valid 5 cycles, send 4..8 -> single burst_done, no errors. Repeat with rst asserted after word 3 -> ready=0 for the reset cycle; the next burst 1..8 is accepted cleanly.
- RX_TIMEOUT_EN, TIMEOUT=16: send 1,2,3, then valid low 16 cycles -> timeout_pulse once; next words 1..8 form a clean burst with no errors.
